// File: rtl/y86_data_mem_hs.sv
// Y86-64 data memory: synchronous word RAM behind a valid/ready request/response
// handshake with configurable read latency, byte enables and range/alignment errors.
module y86_data_mem_hs #(
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 64,
  parameter int LATENCY     = 1,
  parameter int CHECK_ALIGN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic [1:0]            resp_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? ($clog2(LATENCY) + 1) : 1;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic                req_ready_r, req_ready_s;
  logic                resp_valid_r, resp_valid_s;
  logic [DATA_W-1:0]   resp_rdata_r, resp_rdata_s;
  logic [1:0]          resp_err_r, resp_err_s;
  logic                cap_write_r;
  logic [1:0]          cap_err_r;
  logic [DATA_W-1:0]   cap_rdata_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];

  logic                accept_s;
  logic [1:0]          req_err_s;
  logic [IDX_W-1:0]    req_idx_s;

  // Range beats alignment when an address is both out of range and misaligned.
  function automatic logic [1:0] classify(input logic [ADDR_W-1:0] addr);
    logic [1:0] err;
    if (|addr[ADDR_W-1:OFF_W+IDX_W]) begin
      err = ERR_RANGE;
    end else if ((CHECK_ALIGN != 0) && (|addr[OFF_W-1:0])) begin
      err = ERR_ALIGN;
    end else begin
      err = ERR_OK;
    end
    return err;
  endfunction

  assign accept_s  = req_valid && req_ready_r && (state_r == ST_IDLE);
  assign req_err_s = classify(req_addr);
  assign req_idx_s = req_addr[OFF_W +: IDX_W];

  // Next-state and latency counter.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (LATENCY == 1) begin
            state_s = ST_RESP;
          end else begin
            state_s = ST_WAIT;
            cnt_s   = CNT_W'(LATENCY - 1);
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r <= CNT_W'(1)) begin
          state_s = ST_RESP;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s   = cnt_r - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_valid_r && resp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Response register values; presented one cycle after entering RESP, held until taken.
  always_comb begin
    resp_valid_s = resp_valid_r;
    resp_rdata_s = resp_rdata_r;
    resp_err_s   = resp_err_r;
    req_ready_s  = (state_s == ST_IDLE);
    if ((state_r == ST_RESP) && !resp_valid_r) begin
      resp_valid_s = 1'b1;
      resp_err_s   = cap_err_r;
      if ((cap_err_r == ERR_OK) && !cap_write_r) begin
        resp_rdata_s = cap_rdata_r;
      end else begin
        resp_rdata_s = {DATA_W{1'b0}};
      end
    end else if (resp_valid_r && resp_ready) begin
      resp_valid_s = 1'b0;
      resp_rdata_s = {DATA_W{1'b0}};
      resp_err_s   = ERR_OK;
    end else begin
      resp_valid_s = resp_valid_r;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      req_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= {DATA_W{1'b0}};
      resp_err_r   <= ERR_OK;
      cap_write_r  <= 1'b0;
      cap_err_r    <= ERR_OK;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      req_ready_r  <= req_ready_s;
      resp_valid_r <= resp_valid_s;
      resp_rdata_r <= resp_rdata_s;
      resp_err_r   <= resp_err_s;
      if (accept_s) begin
        cap_write_r <= req_write;
        cap_err_r   <= req_err_s;
      end
    end
  end

  // RAM storage is not reset; read data is sampled before a same-edge write lands.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      cap_rdata_r <= mem_r[req_idx_s];
      if (req_write && (req_err_s == ERR_OK)) begin
        for (int b = 0; b < BE_W; b++) begin
          if (req_be[b]) begin
            mem_r[req_idx_s][8*b +: 8] <= req_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_y86_data_mem_hs.sv
// Bench for y86_data_mem_hs: one instance at latency 1, one at latency 4, checked
// against a word-array reference model, constant vector table and corner sequences.
module tb_y86_data_mem_hs;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid, req_ready, req_write, resp_valid, resp_ready;
  logic [1:0][63:0] req_addr, req_wdata, resp_rdata;
  logic [1:0][7:0]  req_be;
  logic [1:0][1:0]  resp_err;

  int checks = 0;
  int errors = 0;
  logic [63:0] model [2][256];

  always #5 clk = ~clk;

  y86_data_mem_hs #(.LATENCY(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  y86_data_mem_hs #(.LATENCY(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    int          hold;
    logic [63:0] exp_rdata;
    logic [1:0]  exp_err;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [1:0] model_err(input logic [63:0] a);
    if ((a / 64'd8) >= 64'd256) return 2'b01;
    if ((a % 64'd8) != 64'd0) return 2'b10;
    return 2'b00;
  endfunction

  // Reference-model effect of a request accepted now; returns expected response.
  task automatic model_accept(input int d, input logic wr, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [7:0] be,
                              output logic [63:0] exp_rd, output logic [1:0] exp_er);
    int idx;
    exp_er = model_err(addr);
    exp_rd = 64'd0;
    if (exp_er == 2'b00) begin
      idx = int'(addr / 64'd8);
      if (!wr) begin
        exp_rd = model[d][idx];
      end else begin
        for (int b = 0; b < 8; b++)
          if (be[b]) model[d][idx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
  endtask

  // One full transaction, starting and ending at a negedge.
  task automatic access(input int d, input logic wr, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] be, input int hold,
                        output logic [63:0] rd, output logic [1:0] er);
    int n, k;
    logic rr_bad, st_bad;
    logic [63:0] exp_rd;
    logic [1:0] exp_er;
    rd = 64'd0;
    er = 2'b00;
    req_write[d] = wr; req_addr[d] = addr; req_wdata[d] = wdata; req_be[d] = be;
    req_valid[d] = 1'b1;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      check("accept_timeout", 64'(n), 64'd0);
      req_valid[d] = 1'b0;
      return;
    end
    model_accept(d, wr, addr, wdata, be, exp_rd, exp_er);
    @(negedge clk);
    req_valid[d] = 1'b0;
    k = 0;
    rr_bad = 1'b0;
    while (resp_valid[d] !== 1'b1 && k < 50) begin
      if (req_ready[d] !== 1'b0) rr_bad = 1'b1;
      @(negedge clk);
      k++;
    end
    if (req_ready[d] !== 1'b0) rr_bad = 1'b1;
    check("latency", 64'(k), 64'(lat_of(d)));
    check("req_ready_low", {63'd0, rr_bad}, 64'd0);
    if (k >= 50) return;
    rd = resp_rdata[d];
    er = resp_err[d];
    check("model_rdata", rd, exp_rd);
    check("model_err", {62'd0, er}, {62'd0, exp_er});
    st_bad = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (resp_valid[d] !== 1'b1 || resp_rdata[d] !== rd || resp_err[d] !== er) st_bad = 1'b1;
    end
    if (hold > 0) check("hold_stable", {63'd0, st_bad}, 64'd0);
    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
    check("resp_valid_drop", {63'd0, resp_valid[d]}, 64'd0);
    check("req_ready_back", {63'd0, req_ready[d]}, 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vt [15];
    logic [63:0] rd, wd, a;
    logic [1:0]  er;
    logic [63:0] exp_rd;
    logic [1:0]  exp_er;
    int          n;

    vt[0]  = '{1'b1, 64'h10,  64'h1122334455667788, 8'hFF, 0, 64'h0, 2'b00};
    vt[1]  = '{1'b0, 64'h10,  64'h0, 8'hFF, 0, 64'h1122334455667788, 2'b00};
    vt[2]  = '{1'b1, 64'h20,  64'hFFFFFFFFFFFFFFFF, 8'hFF, 0, 64'h0, 2'b00};
    vt[3]  = '{1'b1, 64'h20,  64'h0, 8'h0F, 1, 64'h0, 2'b00};
    vt[4]  = '{1'b0, 64'h20,  64'h0, 8'h00, 2, 64'hFFFFFFFF00000000, 2'b00};
    vt[5]  = '{1'b0, 64'h800, 64'h0, 8'h00, 0, 64'h0, 2'b01};
    vt[6]  = '{1'b0, 64'h13,  64'h0, 8'h00, 0, 64'h0, 2'b10};
    vt[7]  = '{1'b1, 64'h0,   64'hA5A5A5A5A5A5A5A5, 8'hFF, 0, 64'h0, 2'b00};
    vt[8]  = '{1'b1, 64'h803, 64'hDEADBEEFDEADBEEF, 8'hFF, 0, 64'h0, 2'b01};
    vt[9]  = '{1'b0, 64'h0,   64'h0, 8'h00, 0, 64'hA5A5A5A5A5A5A5A5, 2'b00};
    vt[10] = '{1'b1, 64'h13,  64'h5555555555555555, 8'hFF, 0, 64'h0, 2'b10};
    vt[11] = '{1'b0, 64'h10,  64'h0, 8'h00, 0, 64'h1122334455667788, 2'b00};
    vt[12] = '{1'b1, 64'h7F8, 64'h0123456789ABCDEF, 8'hFF, 0, 64'h0, 2'b00};
    vt[13] = '{1'b0, 64'h7F8, 64'h0, 8'h00, 0, 64'h0123456789ABCDEF, 2'b00};
    vt[14] = '{1'b0, 64'h801, 64'h0, 8'h00, 0, 64'h0, 2'b01};

    rst_n = 1'b0;
    req_valid = 2'b00; req_write = 2'b00; resp_ready = 2'b00;
    req_addr = '0; req_wdata = '0; req_be = '0;

    // Reset state of both instances.
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", {63'd0, req_ready[d]}, 64'd0);
      check("rst_resp_valid", {63'd0, resp_valid[d]}, 64'd0);
      check("rst_rdata", resp_rdata[d], 64'd0);
      check("rst_err", {62'd0, resp_err[d]}, 64'd0);
    end
    rst_n = 1'b1;
    #1 check("ready_after_release", {62'd0, req_ready}, 64'd0);
    @(negedge clk);
    check("ready_first_edge", {62'd0, req_ready}, 64'd3);

    // Fill both RAMs so every later read has a known model value.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++)
        access(d, 1'b1, 64'(i) * 64'd8, {$urandom, $urandom}, 8'hFF, 0, rd, er);

    // Constant vector table on the latency-1 instance.
    for (int i = 0; i < 15; i++) begin
      access(0, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].be, vt[i].hold, rd, er);
      check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
      check($sformatf("vec%0d_err", i), {62'd0, er}, {62'd0, vt[i].exp_err});
    end

    // Latency 4 with a consumer stalling five cycles.
    access(1, 1'b1, 64'h40, 64'h0F1E2D3C4B5A6978, 8'hFF, 0, rd, er);
    access(1, 1'b0, 64'h40, 64'h0, 8'h00, 5, rd, er);
    check("lat4_rdata", rd, 64'h0F1E2D3C4B5A6978);
    access(1, 1'b0, 64'h805, 64'h0, 8'h00, 5, rd, er);
    check("lat4_err_range", {62'd0, er}, 64'd1);

    // Reset while the latency-4 instance waits on an accepted write.
    req_write[1] = 1'b1; req_addr[1] = 64'h30; req_wdata[1] = 64'hCAFEF00D12345678;
    req_be[1] = 8'hFF; req_valid[1] = 1'b1;
    n = 0;
    while (req_ready[1] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("rst_seq_accept", 64'(n), 64'd0);
    model_accept(1, 1'b1, 64'h30, 64'hCAFEF00D12345678, 8'hFF, exp_rd, exp_er);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_resp_valid", {63'd0, resp_valid[1]}, 64'd0);
    check("midrst_req_ready", {63'd0, req_ready[1]}, 64'd0);
    check("midrst_rdata", resp_rdata[1], 64'd0);
    check("midrst_err", {62'd0, resp_err[1]}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready_back", {63'd0, req_ready[1]}, 64'd1);
    check("midrst_no_resp", {63'd0, resp_valid[1]}, 64'd0);
    access(1, 1'b0, 64'h30, 64'h0, 8'h00, 0, rd, er);
    check("midrst_write_kept", rd, 64'hCAFEF00D12345678);

    // Random alternating write/read stream with random consumer stalls.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) begin
        a = 64'($urandom_range(0, 255)) * 64'd8;
        if ((i % 4) == 3) a = a + 64'($urandom_range(1, 7));
        if ((i % 7) == 5) a = a + 64'h800;
        wd = {$urandom, $urandom};
        access(d, 1'b1, a, wd, 8'($urandom), $urandom_range(0, 3), rd, er);
        access(d, 1'b0, a, 64'h0, 8'h00, $urandom_range(0, 3), rd, er);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
